// File: rtl/trap_ctrl.sv
// Trap/MRET sequencer: flushes the pipeline, updates mepc/mcause/mstatus through the
// single CSR write port, then redirects fetch to the handler or back to mepc.
module trap_ctrl #(
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
    parameter logic [11:0] MSTATUS_ADDR = 12'h300
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_WAIT,
    input  logic        TRAP_EN,
    input  logic [31:0] TRAP_PC,
    input  logic [31:0] TRAP_CODE,
    input  logic [31:0] TRAP_JMP_TO,
    input  logic        MRET_EN,
    input  logic [31:0] MEPC_IN,
    input  logic [31:0] MSTATUS_IN,
    output logic        INT_ALLOW,
    output logic        FLUSH,
    output logic        CSR_WREN,
    output logic [11:0] CSR_WADDR,
    output logic [31:0] CSR_WDATA,
    output logic        JMP_EN,
    output logic [31:0] JMP_TO,
    output logic        BUSY
);
    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH, S_W_MEPC, S_W_MCAUSE, S_W_MSTATUS, S_JUMP
    } state_t;

    state_t      state_q, state_d;
    logic        is_mret_q, is_mret_d;
    logic [29:0] pc_q, pc_d;
    logic [31:0] code_q, code_d;
    // Jump target: handler address on a trap, mepc on MRET
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mstatus_new;
    logic        step_ok;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            is_mret_q <= 1'b0;
            pc_q      <= '0;
            code_q    <= '0;
            tgt_q     <= '0;
            mstatus_q <= '0;
        end else begin
            state_q   <= state_d;
            is_mret_q <= is_mret_d;
            pc_q      <= pc_d;
            code_q    <= code_d;
            tgt_q     <= tgt_d;
            mstatus_q <= mstatus_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        is_mret_d = is_mret_q;
        pc_d      = pc_q;
        code_d    = code_q;
        tgt_d     = tgt_q;
        mstatus_d = mstatus_q;
        if (!MEM_WAIT) begin
            case (state_q)
                S_IDLE: begin
                    if (TRAP_EN) begin
                        pc_d      = TRAP_PC[31:2];
                        code_d    = TRAP_CODE;
                        tgt_d     = TRAP_JMP_TO;
                        mstatus_d = MSTATUS_IN;
                        is_mret_d = 1'b0;
                        state_d   = S_FLUSH;
                    end else if (MRET_EN) begin
                        tgt_d     = MEPC_IN;
                        mstatus_d = MSTATUS_IN;
                        is_mret_d = 1'b1;
                        state_d   = S_FLUSH;
                    end
                end
                S_FLUSH:     state_d = is_mret_q ? S_W_MSTATUS : S_W_MEPC;
                S_W_MEPC:    state_d = S_W_MCAUSE;
                S_W_MCAUSE:  state_d = S_W_MSTATUS;
                S_W_MSTATUS: state_d = S_JUMP;
                S_JUMP:      state_d = S_IDLE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        mstatus_new = mstatus_q;
        if (is_mret_q) begin
            mstatus_new[3] = mstatus_q[7];
            mstatus_new[7] = 1'b1;
        end else begin
            mstatus_new[7] = mstatus_q[3];
            mstatus_new[3] = 1'b0;
        end
        mstatus_new[12:11] = 2'b11;
    end

    assign step_ok   = ~MEM_WAIT & ~RST;
    assign INT_ALLOW = (state_q == S_IDLE) & MSTATUS_IN[3] & ~RST;
    assign BUSY      = (state_q != S_IDLE) & ~RST;

    always_comb begin
        FLUSH     = 1'b0;
        CSR_WREN  = 1'b0;
        CSR_WADDR = '0;
        CSR_WDATA = '0;
        JMP_EN    = 1'b0;
        JMP_TO    = '0;
        if (step_ok) begin
            case (state_q)
                S_FLUSH: FLUSH = 1'b1;
                S_W_MEPC: begin
                    CSR_WREN  = 1'b1;
                    CSR_WADDR = MEPC_ADDR;
                    CSR_WDATA = {pc_q, 2'b00};
                end
                S_W_MCAUSE: begin
                    CSR_WREN  = 1'b1;
                    CSR_WADDR = MCAUSE_ADDR;
                    CSR_WDATA = code_q;
                end
                S_W_MSTATUS: begin
                    CSR_WREN  = 1'b1;
                    CSR_WADDR = MSTATUS_ADDR;
                    CSR_WDATA = mstatus_new;
                end
                S_JUMP: begin
                    JMP_EN = 1'b1;
                    JMP_TO = is_mret_q ? {tgt_q[31:2], 2'b00} : tgt_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: trap, MRET, priority, stall, interrupt gating and reset cases.
module tb_trap_ctrl;
    logic        CLK = 1'b0;
    logic        RST, MEM_WAIT, TRAP_EN, MRET_EN;
    logic [31:0] TRAP_PC, TRAP_CODE, TRAP_JMP_TO, MEPC_IN, MSTATUS_IN;
    logic        INT_ALLOW, FLUSH, CSR_WREN, JMP_EN, BUSY;
    logic [11:0] CSR_WADDR;
    logic [31:0] CSR_WDATA, JMP_TO;

    int n_assert = 0;
    int n_fail   = 0;

    trap_ctrl dut (
        .CLK(CLK), .RST(RST), .MEM_WAIT(MEM_WAIT), .TRAP_EN(TRAP_EN),
        .TRAP_PC(TRAP_PC), .TRAP_CODE(TRAP_CODE), .TRAP_JMP_TO(TRAP_JMP_TO),
        .MRET_EN(MRET_EN), .MEPC_IN(MEPC_IN), .MSTATUS_IN(MSTATUS_IN),
        .INT_ALLOW(INT_ALLOW), .FLUSH(FLUSH), .CSR_WREN(CSR_WREN),
        .CSR_WADDR(CSR_WADDR), .CSR_WDATA(CSR_WDATA), .JMP_EN(JMP_EN),
        .JMP_TO(JMP_TO), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic fl, input logic we,
                           input logic [11:0] wa, input logic [31:0] wd,
                           input logic je, input logic [31:0] jt, input logic bz);
        check({tag, ".flush"}, {31'd0, FLUSH}, {31'd0, fl});
        check({tag, ".wren"},  {31'd0, CSR_WREN}, {31'd0, we});
        check({tag, ".waddr"}, {20'd0, CSR_WADDR}, {20'd0, wa});
        check({tag, ".wdata"}, CSR_WDATA, wd);
        check({tag, ".jmp_en"}, {31'd0, JMP_EN}, {31'd0, je});
        check({tag, ".jmp_to"}, JMP_TO, jt);
        check({tag, ".busy"},  {31'd0, BUSY}, {31'd0, bz});
        $display("%0t %s: flush=%b wren=%b waddr=%h wdata=%h jmp=%b to=%h busy=%b int=%b",
                 $time, tag, FLUSH, CSR_WREN, CSR_WADDR, CSR_WDATA, JMP_EN, JMP_TO, BUSY, INT_ALLOW);
    endtask

    // Called in the cycle right after the accepting edge; walks the whole trap sequence.
    task automatic trap_seq(input string tag, input logic [31:0] pc, input logic [31:0] code,
                            input logic [31:0] jmp, input logic [31:0] ms_exp);
        logic [31:0] pc_al;
        pc_al = {pc[31:2], 2'b00};
        chk_out({tag, ".flush"}, 1, 0, 12'h0, 0, 0, 0, 1);
        check({tag, ".int_busy"}, {31'd0, INT_ALLOW}, 32'd0);
        step(); chk_out({tag, ".mepc"},    0, 1, 12'h341, pc_al, 0, 0, 1);
        step(); chk_out({tag, ".mcause"},  0, 1, 12'h342, code, 0, 0, 1);
        step(); chk_out({tag, ".mstatus"}, 0, 1, 12'h300, ms_exp, 0, 0, 1);
        step(); chk_out({tag, ".jump"},    0, 0, 12'h0, 0, 1, jmp, 1);
        step(); chk_out({tag, ".idle"},    0, 0, 12'h0, 0, 0, 0, 0);
    endtask

    initial begin
        RST = 1; MEM_WAIT = 0; TRAP_EN = 0; MRET_EN = 0;
        TRAP_PC = 0; TRAP_CODE = 0; TRAP_JMP_TO = 0; MEPC_IN = 0; MSTATUS_IN = 32'h8;
        step(); step();
        chk_out("reset", 0, 0, 12'h0, 0, 0, 0, 0);
        check("reset.int_allow", {31'd0, INT_ALLOW}, 32'd0);
        RST = 0; #1;
        check("idle.int_allow_mie1", {31'd0, INT_ALLOW}, 32'd1);

        // Basic trap
        TRAP_EN = 1; TRAP_PC = 32'h100; TRAP_CODE = 32'h2; TRAP_JMP_TO = 32'h200;
        step(); TRAP_EN = 0;
        trap_seq("trap", 32'h100, 32'h2, 32'h200, 32'h1880);
        check("trap.int_allow_after", {31'd0, INT_ALLOW}, 32'd1);

        // MRET, with a TRAP_EN pulse while busy that must be ignored
        MSTATUS_IN = 32'h1880; MEPC_IN = 32'h106; MRET_EN = 1;
        step(); MRET_EN = 0;
        chk_out("mret.flush", 1, 0, 12'h0, 0, 0, 0, 1);
        step(); chk_out("mret.mstatus", 0, 1, 12'h300, 32'h1888, 0, 0, 1);
        TRAP_EN = 1;
        step(); TRAP_EN = 0; #1;
        chk_out("mret.jump", 0, 0, 12'h0, 0, 1, 32'h104, 1);
        step(); chk_out("mret.idle", 0, 0, 12'h0, 0, 0, 0, 0);
        step(); chk_out("busy_trap_ignored", 0, 0, 12'h0, 0, 0, 0, 0);

        // Simultaneous TRAP_EN and MRET_EN: trap wins
        MSTATUS_IN = 32'h8; MEPC_IN = 32'h500;
        TRAP_EN = 1; MRET_EN = 1; TRAP_PC = 32'h204; TRAP_CODE = 32'h8000000B; TRAP_JMP_TO = 32'h300;
        step(); TRAP_EN = 0; MRET_EN = 0;
        trap_seq("both", 32'h204, 32'h8000000B, 32'h300, 32'h1880);

        // MEM_WAIT stall of 3 cycles at W_MCAUSE; MIE=0 so no interrupts allowed
        MSTATUS_IN = 32'h0; #1;
        check("idle.int_allow_mie0", {31'd0, INT_ALLOW}, 32'd0);
        TRAP_EN = 1; TRAP_PC = 32'h10F; TRAP_CODE = 32'h5; TRAP_JMP_TO = 32'h400;
        step(); TRAP_EN = 0;
        chk_out("stall.flush", 1, 0, 12'h0, 0, 0, 0, 1);
        step(); chk_out("stall.mepc", 0, 1, 12'h341, 32'h10C, 0, 0, 1);
        step(); MEM_WAIT = 1; #1;
        for (int i = 0; i < 3; i++) begin
            chk_out($sformatf("stall.wait%0d", i), 0, 0, 12'h0, 0, 0, 0, 1);
            if (i < 2) step();
        end
        step(); MEM_WAIT = 0; #1;
        chk_out("stall.mcause", 0, 1, 12'h342, 32'h5, 0, 0, 1);
        step(); chk_out("stall.mstatus", 0, 1, 12'h300, 32'h1800, 0, 0, 1);
        step(); chk_out("stall.jump", 0, 0, 12'h0, 0, 1, 32'h400, 1);
        step(); chk_out("stall.idle", 0, 0, 12'h0, 0, 0, 0, 0);

        // MEM_WAIT in IDLE blocks sampling
        MSTATUS_IN = 32'h8; MEM_WAIT = 1; TRAP_EN = 1; TRAP_PC = 32'h800; TRAP_CODE = 32'h7; TRAP_JMP_TO = 32'h900;
        step(); chk_out("idle_wait", 0, 0, 12'h0, 0, 0, 0, 0);
        MEM_WAIT = 0;
        step(); TRAP_EN = 0;
        chk_out("idle_wait.flush", 1, 0, 12'h0, 0, 0, 0, 1);

        // Reset during W_MEPC, then a fresh full trap
        step(); chk_out("rst.mepc", 0, 1, 12'h341, 32'h800, 0, 0, 1);
        RST = 1;
        step(); chk_out("rst.after", 0, 0, 12'h0, 0, 0, 0, 0);
        check("rst.int_allow", {31'd0, INT_ALLOW}, 32'd0);
        RST = 0;
        step(); chk_out("rst.idle", 0, 0, 12'h0, 0, 0, 0, 0);
        check("rst.int_allow_idle", {31'd0, INT_ALLOW}, 32'd1);
        TRAP_EN = 1; TRAP_PC = 32'hABC; TRAP_CODE = 32'h3; TRAP_JMP_TO = 32'hF00;
        step(); TRAP_EN = 0;
        trap_seq("post_rst", 32'hABC, 32'h3, 32'hF00, 32'h1880);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequencer that sits after the trap information unit and the MRET decode path.
- On a trap it flushes the pipeline, writes mepc, mcause and mstatus in order through the single CSR write port, then issues the jump to the handler.
- On MRET it restores mstatus and jumps to mepc.
- It also generates INT_ALLOW back to the trap unit, which gates interrupt acceptance while a sequence is in flight.

Parameters:
- MEPC_ADDR, 12'h341, CSR address for mepc.
- MCAUSE_ADDR, 12'h342, CSR address for mcause.
- MSTATUS_ADDR, 12'h300, CSR address for mstatus.

Ports:
- CLK  in  1  clock; single clock domain.
- RST  in  1  synchronous, active-high reset.
- MEM_WAIT  in  1  memory stall; freezes the sequence.
- TRAP_EN  in  1  trap request from the trap unit.
- TRAP_PC  in  32  faulting/interrupted PC.
- TRAP_CODE  in  32  mcause value.
- TRAP_JMP_TO  in  32  handler address.
- MRET_EN  in  1  MRET retiring.
- MEPC_IN  in  32  current mepc CSR value.
- MSTATUS_IN  in  32  current mstatus CSR value.
- INT_ALLOW  out  1  interrupts may be taken.
- FLUSH  out  1  pipeline flush pulse.
- CSR_WREN  out  1  CSR write strobe.
- CSR_WADDR  out  12  CSR write address.
- CSR_WDATA  out  32  CSR write data.
- JMP_EN  out  1  redirect fetch strobe.
- JMP_TO  out  32  redirect target.
- BUSY  out  1  sequence in progress (state != IDLE).

Behaviour:
- States: IDLE, FLUSH, W_MEPC, W_MCAUSE, W_MSTATUS, JUMP. An internal flag `is_mret` selects the path.
- Reset: state=IDLE, `is_mret`=0, all latches 0, all outputs 0 (INT_ALLOW=0 during reset).
- IDLE, MEM_WAIT=0:
  - TRAP_EN=1: latch TRAP_PC, TRAP_CODE, TRAP_JMP_TO, MSTATUS_IN; set `is_mret`=0; go to FLUSH.
  - Else MRET_EN=1: latch MEPC_IN, MSTATUS_IN; set `is_mret`=1; go to FLUSH.
  - TRAP_EN has priority over a simultaneous MRET_EN; the MRET is dropped because it is flushed.
- IDLE, MEM_WAIT=1: requests are not sampled; stay in IDLE.
- Transitions:
  - FLUSH: FLUSH=1 for exactly one cycle. Next state is W_MEPC for a trap, W_MSTATUS for MRET.
  - W_MEPC: CSR_WREN=1, CSR_WADDR=MEPC_ADDR, CSR_WDATA={latched PC[31:2],2'b00}. Next W_MCAUSE.
  - W_MCAUSE: CSR_WREN=1, CSR_WADDR=MCAUSE_ADDR, CSR_WDATA=latched code. Next W_MSTATUS.
  - W_MSTATUS: CSR_WREN=1, CSR_WADDR=MSTATUS_ADDR. Next JUMP.
    - Trap data: latched mstatus with bit7 (MPIE)=old bit3, bit3 (MIE)=0, bits12:11 (MPP)=2'b11.
    - MRET data: bit3=old bit7, bit7=1, bits12:11=2'b11.
    - All other bits pass through unchanged.
  - JUMP: JMP_EN=1, JMP_TO=latched handler address (trap) or latched mepc with bits1:0 cleared (MRET). Next IDLE.
- Outputs in other states: CSR_WREN, JMP_EN and FLUSH are 0 outside their own states. CSR_WADDR, CSR_WDATA and JMP_TO read 0 whenever their strobe is 0.
- MEM_WAIT=1 in any non-IDLE state: the state holds and FLUSH, CSR_WREN and JMP_EN are forced to 0. The step is performed on the first cycle with MEM_WAIT=0. No step is skipped or duplicated.
- Latency with no stalls, request sampled at edge k:
  - Trap: FLUSH in cycle k+1, mepc write k+2, mcause write k+3, mstatus write k+4, JMP_EN k+5, IDLE from k+6.
  - MRET: FLUSH k+1, mstatus write k+2, JMP_EN k+3.
- TRAP_EN and MRET_EN arriving while BUSY=1 are ignored. A TRAP_EN still high on return to IDLE is accepted as a new trap.
- INT_ALLOW = (state==IDLE) & MSTATUS_IN[3] & ~RST. This is combinational from registered state.
- RST asserted mid-sequence: next edge goes to IDLE with all outputs 0. Partially written CSRs are not rolled back.

Test Plan:
- Trap, no stall: MSTATUS_IN=32'h8, TRAP_EN pulse with PC=32'h100, code=32'h2, JMP_TO=32'h200.
  - Required: FLUSH at k+1.
  - Writes (341,32'h100), (342,32'h2), (300,32'h1880) at k+2..k+4.
  - JMP_EN at k+5 with JMP_TO=32'h200. BUSY high k+1..k+5.
- MRET: MSTATUS_IN=32'h1880, MEPC_IN=32'h106, MRET_EN pulse.
  - Required: FLUSH k+1, write (300,32'h1888) at k+2, JMP_EN with JMP_TO=32'h104 at k+3.
- Simultaneous TRAP_EN and MRET_EN: trap sequence runs (5 steps), no MRET mstatus write occurs.
- MEM_WAIT=1 for 3 cycles starting at the W_MCAUSE cycle: CSR_WREN low for 3 cycles, then the mcause write occurs once, then mstatus, then jump. Total completion delayed exactly 3 cycles.
- INT_ALLOW: with MSTATUS_IN[3]=1, INT_ALLOW=1 in IDLE, 0 throughout the sequence; with MSTATUS_IN[3]=0 it is 0. A TRAP_EN pulse during BUSY produces no second sequence.
- RST asserted during W_MEPC: next cycle state IDLE, all outputs 0, BUSY=0. A later TRAP_EN starts a fresh full sequence.
